mpc_hilo_ctrl: RTL and testbench

HI/LO register controller that sits between decode/issue and the unsigned integer multiplier. It accepts MULT/MULTU/MFHI/MFLO/MTHI/MTLO commands and converts signed operands to magnitudes. It launches the multiplier, waits for its ready pulse, sign-corrects the 64-bit product and commits it to HI/LO. MFHI/MFLO are stalled while a multiply is in flight.

---
 rtl/mpc_hilo_ctrl_pkg.sv | 15 +
 rtl/mpc_signed_mag.sv | 13 +
 rtl/mpc_hilo_ctrl.sv | 103 ++++++++++
 tb/tb_mpc_hilo_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mpc_hilo_ctrl_pkg.sv
// mpc_hilo_ctrl_pkg: shared width, HI/LO opcode and FSM state constants.
package mpc_hilo_ctrl_pkg;
  localparam int HILO_DATA_WIDTH = 32;
  localparam logic [2:0] HILO_NOP   = 3'd0;
  localparam logic [2:0] HILO_MULT  = 3'd1;
  localparam logic [2:0] HILO_MULTU = 3'd2;
  localparam logic [2:0] HILO_MFHI  = 3'd3;
  localparam logic [2:0] HILO_MFLO  = 3'd4;
  localparam logic [2:0] HILO_MTHI  = 3'd5;
  localparam logic [2:0] HILO_MTLO  = 3'd6;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FIX    = 2'd3;
endpackage

// File: rtl/mpc_signed_mag.sv
// mpc_signed_mag: splits an operand into unsigned magnitude and sign.
module mpc_signed_mag #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         signed_i,
  output logic [W-1:0] mag_o,
  output logic         neg_o
);
  // The most negative value negates to itself, which is its correct unsigned magnitude.
  assign neg_o = signed_i & val_i[W-1];
  assign mag_o = neg_o ? -val_i : val_i;
endmodule

// File: rtl/mpc_hilo_ctrl.sv
// mpc_hilo_ctrl: HI/LO register controller fronting an unsigned variable-latency multiplier.
module mpc_hilo_ctrl
  import mpc_hilo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = HILO_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iCmdValid,
  input  logic [2:0]              iCmdOp,
  input  logic [DATA_WIDTH-1:0]   iRs,
  input  logic [DATA_WIDTH-1:0]   iRt,
  output logic                    oCmdReady,
  output logic                    oMulValid,
  output logic [DATA_WIDTH-1:0]   oMulA,
  output logic [DATA_WIDTH-1:0]   oMulB,
  input  logic [2*DATA_WIDTH-1:0] iMul,
  input  logic                    iMulReady,
  output logic                    oRdValid,
  output logic [DATA_WIDTH-1:0]   oRdData,
  output logic [DATA_WIDTH-1:0]   oHi,
  output logic [DATA_WIDTH-1:0]   oLo,
  output logic                    oBusy
);
  logic [1:0]              state_q, state_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d, rd_q, rd_d;
  logic [2*DATA_WIDTH-1:0] prod_q, prod_d;
  logic                    neg_q, neg_d, rv_q, rv_d;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b;
  logic                    neg_a, neg_b, is_signed;
  assign is_signed = iCmdOp == HILO_MULT;
  mpc_signed_mag #(.W(DATA_WIDTH)) u_mag_a (.val_i(iRs), .signed_i(is_signed), .mag_o(mag_a), .neg_o(neg_a));
  mpc_signed_mag #(.W(DATA_WIDTH)) u_mag_b (.val_i(iRt), .signed_i(is_signed), .mag_o(mag_b), .neg_o(neg_b));
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    rd_d    = rd_q;
    rv_d    = 1'b0;
    case (state_q)
      S_IDLE: if (iCmdValid) begin
        if (iCmdOp == HILO_MULT || iCmdOp == HILO_MULTU) begin
          a_d     = mag_a;
          b_d     = mag_b;
          neg_d   = neg_a ^ neg_b;
          state_d = S_LAUNCH;
        end
        if (iCmdOp == HILO_MFHI || iCmdOp == HILO_MFLO) begin
          rv_d = 1'b1;
          rd_d = iCmdOp == HILO_MFHI ? hi_q : lo_q;
        end
        if (iCmdOp == HILO_MTHI) hi_d = iRs;
        if (iCmdOp == HILO_MTLO) lo_d = iRs;
      end
      S_LAUNCH: state_d = S_WAIT;
      // Ready pulses outside WAIT are stale and deliberately dropped.
      S_WAIT: if (iMulReady) begin
        prod_d  = iMul;
        state_d = S_FIX;
      end
      default: begin
        {hi_d, lo_d} = neg_q ? -prod_q : prod_q;
        state_d      = S_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
      rd_q    <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
      rd_q    <= rd_d;
      rv_q    <= rv_d;
    end
  end
  assign oCmdReady = state_q == S_IDLE;
  assign oMulValid = state_q == S_LAUNCH;
  assign oBusy     = state_q != S_IDLE;
  assign oMulA     = a_q;
  assign oMulB     = b_q;
  assign oRdValid  = rv_q;
  assign oRdData   = rd_q;
  assign oHi       = hi_q;
  assign oLo       = lo_q;
endmodule

// File: tb/tb_mpc_hilo_ctrl.sv
// tb_mpc_hilo_ctrl: directed HI/LO controller test with a reference model and multiplier stub.
module tb_mpc_hilo_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        iCmdValid = 1'b0;
  logic [2:0]  iCmdOp = 3'd0;
  logic [31:0] iRs = '0, iRt = '0;
  logic        oCmdReady, oMulValid, oRdValid, oBusy;
  logic [31:0] oMulA, oMulB, oRdData, oHi, oLo;
  logic [63:0] iMul = '0;
  logic        iMulReady = 1'b0;
  int          vectors = 0, errs = 0;
  int          lat = 4;
  bit          spur = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, exp_rd = '0, exp_a = '0, exp_b = '0;
  logic [31:0] last_rd = '0, last_a = '0, last_b = '0, ma, mb;
  bit          exp_rv = 1'b0, exp_launch = 1'b0;
  logic signed [63:0] sa, sb, sp;
  always #5 clk = ~clk;
  mpc_hilo_ctrl dut (
    .clk(clk), .reset(reset), .iCmdValid(iCmdValid), .iCmdOp(iCmdOp), .iRs(iRs), .iRt(iRt),
    .oCmdReady(oCmdReady), .oMulValid(oMulValid), .oMulA(oMulA), .oMulB(oMulB),
    .iMul(iMul), .iMulReady(iMulReady), .oRdValid(oRdValid), .oRdData(oRdData),
    .oHi(oHi), .oLo(oLo), .oBusy(oBusy)
  );
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  // Reference model: architectural HI/LO updated when a command is accepted.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst_hi", {32'd0, oHi}, 64'd0);
      chk("rst_lo", {32'd0, oLo}, 64'd0);
      chk("rst_flags", {61'd0, oBusy, oMulValid, oRdValid}, 64'd0);
      chk("rst_data", {oMulA, oRdData}, 64'd0);
      chk("rst_ready", {63'd0, oCmdReady}, 64'd1);
      m_hi = '0; m_lo = '0; exp_rv = 1'b0; exp_launch = 1'b0;
    end else begin
      chk("cmd_ready", {63'd0, oCmdReady}, {63'd0, !oBusy});
      chk("mul_valid", {63'd0, oMulValid}, {63'd0, exp_launch});
      chk("rd_valid", {63'd0, oRdValid}, {63'd0, exp_rv});
      if (exp_launch) begin
        chk("mul_ab", {oMulA, oMulB}, {exp_a, exp_b});
        last_a = oMulA; last_b = oMulB;
      end
      if (exp_rv) begin
        chk("rd_data", {32'd0, oRdData}, {32'd0, exp_rd});
        last_rd = oRdData;
      end
      if (!oBusy) chk("hilo", {oHi, oLo}, {m_hi, m_lo});
      exp_launch = 1'b0; exp_rv = 1'b0;
      if (iCmdValid && oCmdReady) begin
        case (iCmdOp)
          3'd1, 3'd2: begin
            if (iCmdOp == 3'd1) begin
              sa = {{32{iRs[31]}}, iRs}; sb = {{32{iRt[31]}}, iRt};
              exp_a = iRs[31] ? 32'd0 - iRs : iRs;
              exp_b = iRt[31] ? 32'd0 - iRt : iRt;
            end else begin
              sa = {32'd0, iRs}; sb = {32'd0, iRt};
              exp_a = iRs; exp_b = iRt;
            end
            sp = sa * sb;
            {m_hi, m_lo} = sp;
            exp_launch = 1'b1;
          end
          3'd3: begin exp_rv = 1'b1; exp_rd = m_hi; end
          3'd4: begin exp_rv = 1'b1; exp_rd = m_lo; end
          3'd5: m_hi = iRs;
          3'd6: m_lo = iRs;
          default: ;
        endcase
      end
    end
  end
  // Multiplier stub: fixed latency, checks operands stay stable while waiting.
  initial forever begin
    @(negedge clk);
    if (spur) begin
      iMulReady = 1'b1; iMul = 64'hDEAD_BEEF_CAFE_F00D; spur = 1'b0;
      @(negedge clk);
      iMulReady = 1'b0;
    end else if (oMulValid && !reset) begin
      ma = oMulA; mb = oMulB;
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        if (oBusy && !reset) chk("mul_stable", {oMulA, oMulB}, {ma, mb});
      end
      iMulReady = 1'b1; iMul = {32'd0, ma} * {32'd0, mb};
      @(negedge clk);
      iMulReady = 1'b0;
    end
  end
  task automatic cmd(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bit ok = 1'b0;
    iCmdValid = 1'b1; iCmdOp = op; iRs = rs; iRt = rt;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = oCmdReady;
    end
    chk("accept_bound", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    iCmdValid = 1'b0; iCmdOp = 3'd0;
  endtask
  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = !oBusy;
    end
    chk("idle_bound", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
  endtask
  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    lat = 4;
    cmd(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    chk("multu_max", {oHi, oLo}, 64'hFFFF_FFFE_0000_0001);
    chk("multu_ab", {last_a, last_b}, 64'hFFFF_FFFF_FFFF_FFFF);
    cmd(3'd3, 32'd0, 32'd0); @(posedge clk); #1;
    chk("mfhi_max", {32'd0, last_rd}, 64'hFFFF_FFFE);
    lat = 1;
    cmd(3'd1, 32'hFFFF_FFFD, 32'd5); wait_idle();
    chk("mult_neg", {oHi, oLo}, 64'hFFFF_FFFF_FFFF_FFF1);
    chk("mult_neg_ab", {last_a, last_b}, {32'd3, 32'd5});
    lat = 3;
    cmd(3'd1, 32'h8000_0000, 32'h8000_0000); wait_idle();
    chk("mult_min_sq", {oHi, oLo}, 64'h4000_0000_0000_0000);
    chk("mult_min_ab", {last_a, last_b}, 64'h8000_0000_8000_0000);
    cmd(3'd1, 32'h8000_0000, 32'd1); wait_idle();
    chk("mult_min_1", {oHi, oLo}, 64'hFFFF_FFFF_8000_0000);
    lat = 10;
    cmd(3'd2, 32'd7, 32'd9);
    cmd(3'd4, 32'd0, 32'd0); @(posedge clk); #1;
    chk("mflo_stall", {32'd0, last_rd}, 64'd63);
    cmd(3'd5, 32'h1234_5678, 32'd0);
    cmd(3'd3, 32'd0, 32'd0); @(posedge clk); #1;
    chk("mthi_mfhi", {32'd0, last_rd}, 64'h1234_5678);
    cmd(3'd6, 32'hA5A5_0F0F, 32'd0); cmd(3'd7, 32'hFFFF_FFFF, 32'd1); cmd(3'd0, 32'd1, 32'd1);
    spur = 1'b1; repeat (4) @(posedge clk); #1;
    chk("spurious", {oHi, oLo}, 64'h1234_5678_A5A5_0F0F);
    lat = 10;
    cmd(3'd2, 32'hFFFF_0000, 32'h0001_0000);
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("reset_mid", {oHi, oLo}, 64'd0);
    lat = 2;
    cmd(3'd2, 32'd2, 32'd3); wait_idle();
    chk("after_reset", {oHi, oLo}, 64'd6);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
